// File: rtl/dsc_pkg.sv
// Shared types and default sizing for the deterministic stochastic multiplier.
package dsc_pkg;

    localparam int DSC_DATA_WIDTH = 4;
    localparam int DSC_NUM_INPUTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsc_state_e;

endpackage

// File: rtl/dsc_counter.sv
// Wrapping up-counter with synchronous clear and an all-ones flag.
module dsc_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = &count;

endmodule

// File: rtl/dsc_core.sv
// Exact unsigned product of NUM_INPUTS operands by clock-division unary streams:
// one counter per operand sweeps every combination once and the accumulator counts AND hits.
//
// state | meaning
// IDLE  | waiting for en; on en capture operands, clear counters and accumulator
// RUN   | one combination per enabled cycle; leaves after the all-max combination
// DONE  | result and op_finished held until reset
module dsc_core
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = DSC_DATA_WIDTH,
    parameter int NUM_INPUTS = DSC_NUM_INPUTS
) (
    input  logic                             gclk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [DATA_WIDTH-1:0]            bin_data_in [NUM_INPUTS],
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
    output logic                             op_finished
);

    localparam int ACC_W = NUM_INPUTS * DATA_WIDTH;

    dsc_state_e state_q, state_d;
    logic start, run_step;

    logic [DATA_WIDTH-1:0]                  opnd_q [NUM_INPUTS];
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  cnt;
    logic [NUM_INPUTS-1:0]                  at_max;
    logic [NUM_INPUTS-1:0]                  stream;
    logic [NUM_INPUTS:0]                    chain;
    logic [ACC_W-1:0]                       acc_q;

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        run_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    run_step = 1'b1;
                    if (chain[NUM_INPUTS]) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                opnd_q[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                opnd_q[i] <= bin_data_in[i];
            end
        end
    end

    // chain[i] is high when every lower-order counter sits at its maximum
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        assign chain[i+1] = chain[i] & at_max[i];
        assign stream[i]  = (cnt[i] < opnd_q[i]);

        dsc_counter #(
            .WIDTH (DATA_WIDTH)
        ) u_cnt (
            .clk    (gclk),
            .rst    (rst),
            .clr    (start),
            .inc    (run_step & chain[i]),
            .count  (cnt[i]),
            .at_max (at_max[i])
        );
    end

    always_ff @(posedge gclk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (start) begin
            acc_q <= '0;
        end else if (run_step && (&stream)) begin
            acc_q <= acc_q + 1'b1;
        end
    end

    assign bin_data_out = acc_q;
    assign op_finished  = (state_q == DONE);

endmodule

// File: tb/tb_dsc_core.sv
// Directed bench for dsc_core: table of full K=2 runs plus hand sequences for pause, reset, partial and K=3.
module tb_dsc_core;

    localparam int W = 4;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic           rst2, en2;
    logic [W-1:0]   din2 [2];
    logic [7:0]     dout2;
    logic           fin2;

    logic           rst3, en3;
    logic [W-1:0]   din3 [3];
    logic [11:0]    dout3;
    logic           fin3;

    dsc_core #(.DATA_WIDTH(4), .NUM_INPUTS(2)) dut2 (
        .gclk         (gclk),
        .rst          (rst2),
        .en           (en2),
        .bin_data_in  (din2),
        .bin_data_out (dout2),
        .op_finished  (fin2)
    );

    dsc_core #(.DATA_WIDTH(4), .NUM_INPUTS(3)) dut3 (
        .gclk         (gclk),
        .rst          (rst3),
        .en           (en3),
        .bin_data_in  (din3),
        .bin_data_out (dout3),
        .op_finished  (fin3)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         prod;
    } vec_t;

    vec_t vecs [8];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic reset2();
        en2  = 1'b0;
        rst2 = 1'b0;
        @(negedge gclk);
        rst2 = 1'b1;
    endtask

    task automatic reset3();
        en3  = 1'b0;
        rst3 = 1'b0;
        @(negedge gclk);
        rst3 = 1'b1;
    endtask

    // counts enabled edges until op_finished; bounded so a stuck DUT still reaches the summary
    task automatic run2(output int edges);
        en2   = 1'b1;
        edges = 0;
        while (edges < 400) begin
            @(posedge gclk);
            #1;
            edges++;
            if (fin2) break;
        end
    endtask

    initial begin
        int edges;

        vecs[0] = '{a: 4'd15, b: 4'd15, prod: 225};
        vecs[1] = '{a: 4'd0,  b: 4'd9,  prod: 0};
        vecs[2] = '{a: 4'd1,  b: 4'd1,  prod: 1};
        vecs[3] = '{a: 4'd3,  b: 4'd5,  prod: 15};
        vecs[4] = '{a: 4'd8,  b: 4'd8,  prod: 64};
        vecs[5] = '{a: 4'd9,  b: 4'd0,  prod: 0};
        vecs[6] = '{a: 4'd7,  b: 4'd11, prod: 77};
        vecs[7] = '{a: 4'd2,  b: 4'd15, prod: 30};

        rst2 = 1'b0; en2 = 1'b0; din2[0] = 4'd15; din2[1] = 4'd15;
        rst3 = 1'b0; en3 = 1'b0; din3[0] = 4'd0;  din3[1] = 4'd0; din3[2] = 4'd0;
        #1;
        check("reset_out2", int'(dout2), 0);
        check("reset_fin2", int'(fin2), 0);
        check("reset_out3", int'(dout3), 0);
        check("reset_fin3", int'(fin3), 0);

        for (int v = 0; v < 8; v++) begin
            reset2();
            din2[0] = vecs[v].a;
            din2[1] = vecs[v].b;
            run2(edges);
            check($sformatf("vec%0d_edges", v), edges, 257);
            check($sformatf("vec%0d_prod", v), int'(dout2), vecs[v].prod);
            check($sformatf("vec%0d_fin", v), int'(fin2), 1);
        end

        // DONE ignores en and operand changes; last vector left 2*15
        en2 = 1'b0; din2[0] = 4'd1; din2[1] = 4'd1;
        repeat (5) @(posedge gclk);
        en2 = 1'b1;
        repeat (5) @(posedge gclk);
        #1;
        check("done_hold_prod", int'(dout2), 30);
        check("done_hold_fin", int'(fin2), 1);

        // partial product with 15x15: 7 rows after 112 RUN cycles, 8 rows after 128
        reset2();
        din2[0] = 4'd15; din2[1] = 4'd15;
        en2 = 1'b1;
        repeat (113) @(posedge gclk);
        #1;
        check("partial112_prod", int'(dout2), 105);
        check("partial112_fin", int'(fin2), 0);
        repeat (16) @(posedge gclk);
        #1;
        check("partial128_prod", int'(dout2), 120);
        check("partial128_fin", int'(fin2), 0);

        // 8x8 with a 20-cycle pause after 50 RUN cycles (3 rows x 8 + 2 hits = 26)
        reset2();
        din2[0] = 4'd8; din2[1] = 4'd8;
        en2 = 1'b1;
        repeat (51) @(posedge gclk);
        #1;
        en2 = 1'b0;
        repeat (20) @(posedge gclk);
        #1;
        check("pause_prod", int'(dout2), 26);
        check("pause_fin", int'(fin2), 0);
        run2(edges);
        check("pause_remaining_edges", edges, 206);
        check("pause_final_prod", int'(dout2), 64);

        // reset mid-run at RUN cycle 100 (6 rows x 15 + 4 = 94), then restart 3x5
        reset2();
        din2[0] = 4'd15; din2[1] = 4'd15;
        en2 = 1'b1;
        repeat (101) @(posedge gclk);
        #1;
        check("midrun_prod", int'(dout2), 94);
        @(negedge gclk);
        rst2 = 1'b0;
        #1;
        check("abort_prod", int'(dout2), 0);
        check("abort_fin", int'(fin2), 0);
        @(negedge gclk);
        rst2 = 1'b1;
        din2[0] = 4'd3; din2[1] = 4'd5;
        run2(edges);
        check("restart_edges", edges, 257);
        check("restart_prod", int'(dout2), 15);

        // K=3: 15^3 with operands disturbed after capture
        reset3();
        din3[0] = 4'd15; din3[1] = 4'd15; din3[2] = 4'd15;
        en3 = 1'b1;
        edges = 0;
        while (edges < 5000) begin
            @(posedge gclk);
            #1;
            edges++;
            if (edges == 10) begin
                din3[0] = 4'd0; din3[1] = 4'd1; din3[2] = 4'd2;
            end
            if (fin3) break;
        end
        check("k3_max_edges", edges, 4097);
        check("k3_max_prod", int'(dout3), 3375);

        reset3();
        din3[0] = 4'd2; din3[1] = 4'd3; din3[2] = 4'd4;
        en3 = 1'b1;
        edges = 0;
        while (edges < 5000) begin
            @(posedge gclk);
            #1;
            edges++;
            if (fin3) break;
        end
        check("k3_small_edges", edges, 4097);
        check("k3_small_prod", int'(dout3), 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
